// File: rtl/vga_paint_compositor.sv
// Pixel compositor: sequences RAM init, issues pipelined RAM reads, frame-filters the
// detected glove position into a cursor and overlays crosshair / brush preview on RGB.
module vga_paint_compositor #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_OFFSET    = 145,
  parameter int V_OFFSET    = 36,
  parameter int COORD_W     = 11,
  parameter int ADDR_W      = 20,
  parameter int CH_BITS     = 3,
  parameter int RD_LAT      = 1,
  parameter int FILT_SHIFT  = 2,
  parameter int LOST_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic                 mem_init_req,
  input  logic                 mem_init_done,
  input  logic [COORD_W-1:0]   vga_x,
  input  logic [COORD_W-1:0]   vga_y,
  input  logic                 vga_active,
  input  logic                 vga_vs,
  input  logic                 det_valid,
  input  logic [COORD_W-1:0]   det_x,
  input  logic [COORD_W-1:0]   det_y,
  input  logic [5:0]           radius,
  input  logic                 preview,
  input  logic [3*CH_BITS-1:0] brush_color,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [3*CH_BITS-1:0] rd_data,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic [COORD_W-1:0]   cursor_x,
  output logic [COORD_W-1:0]   cursor_y,
  output logic                 cursor_valid
);

  localparam int PIPE   = RD_LAT + 1;
  localparam int SW     = COORD_W + 2;
  localparam int FW     = COORD_W + 1;
  localparam int LOST_W = $clog2(LOST_FRAMES + 1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (64'(H_ACTIVE) * 64'(V_ACTIVE) > (64'd1 << ADDR_W)) begin : g_addr_chk
    $error("vga_paint_compositor: H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W");
  end
  if (CH_BITS < 1 || CH_BITS > 8) begin : g_ch_chk
    $error("vga_paint_compositor: CH_BITS must be 1..8");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
    $error("vga_paint_compositor: RD_LAT must be 1..4");
  end
  if (LOST_FRAMES < 1) begin : g_lost_chk
    $error("vga_paint_compositor: LOST_FRAMES must be at least 1");
  end

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_t;

  function automatic logic [7:0] expand(input logic [CH_BITS-1:0] c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = c[CH_BITS-1-(i % CH_BITS)];
    return r;
  endfunction

  function automatic logic [23:0] expand_rgb(input logic [3*CH_BITS-1:0] c);
    return {expand(c[3*CH_BITS-1 -: CH_BITS]), expand(c[2*CH_BITS-1 -: CH_BITS]),
            expand(c[CH_BITS-1:0])};
  endfunction

  // Moves cur a 2**-FILT_SHIFT fraction of the way towards goal (floor rounding).
  function automatic logic [COORD_W-1:0] filt(input logic [COORD_W-1:0] cur,
                                              input logic [FW-1:0] goal);
    logic signed [FW-1:0] diff;
    diff = $signed(goal) - $signed({1'b0, cur});
    return cur + COORD_W'(diff >>> FILT_SHIFT);
  endfunction

  logic [0:0] state;

  // NOTE: all clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               state <= ST_INIT;
    else if (clear)                             state <= ST_INIT;
    else if (state == ST_INIT && mem_init_done) state <= ST_RUN;
  end

  assign mem_init_req = (state == ST_INIT);

  logic [ADDR_W-1:0] pix_addr;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    pix_addr = '0;
    pix_addr = (ADDR_W'(vga_y) - ADDR_W'(V_OFFSET)) * ADDR_W'(H_ACTIVE)
             + (ADDR_W'(vga_x) - ADDR_W'(H_OFFSET));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= vga_active & (state == ST_RUN);
      if (vga_active) rd_addr <= pix_addr;
    end
  end

  pix_t pipe [PIPE];

  // NOTE: the alignment pipeline is a handful of flops, not a RAM, so it is reset
  // to keep stale pixels from being composited after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pix_t'{active: vga_active, x: vga_x, y: vga_y};
      for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Detector capture and once-per-frame cursor update.
  logic               vs_q, seen, vs_rise;
  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic [LOST_W-1:0]  lost;
  logic [FW-1:0]      goal_x, goal_y;

  assign vs_rise = vga_vs & ~vs_q;
  assign goal_x  = FW'(tgt_x) + FW'(H_OFFSET);
  assign goal_y  = FW'(tgt_y) + FW'(V_OFFSET);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q         <= 1'b0;
      seen         <= 1'b0;
      tgt_x        <= '0;
      tgt_y        <= '0;
      lost         <= '0;
      cursor_x     <= '0;
      cursor_y     <= '0;
      cursor_valid <= 1'b0;
    end else begin
      vs_q <= vga_vs;
      if (det_valid) begin
        tgt_x <= (det_x > X_MAX) ? X_MAX : det_x;
        tgt_y <= (det_y > Y_MAX) ? Y_MAX : det_y;
      end
      if (vs_rise) begin
        seen <= det_valid;
        if (seen) begin
          lost <= '0;
          if (!cursor_valid) begin
            cursor_x     <= goal_x[COORD_W-1:0];
            cursor_y     <= goal_y[COORD_W-1:0];
            cursor_valid <= 1'b1;
          end else begin
            cursor_x <= filt(cursor_x, goal_x);
            cursor_y <= filt(cursor_y, goal_y);
          end
        end else begin
          if (lost != LOST_W'(LOST_FRAMES)) lost <= lost + 1'b1;
          if (lost >= LOST_W'(LOST_FRAMES - 1)) cursor_valid <= 1'b0;
        end
      end else if (det_valid) begin
        seen <= 1'b1;
      end
    end
  end

  // Compositing on the pixel aligned with rd_data; widened signed math avoids edge wrap.
  pix_t                 out_pix;
  logic signed [SW-1:0] dx, dy, adx, ady, rad_s;
  logic                 on_cross;
  logic [23:0]          rgb_next;

  assign out_pix = pipe[PIPE-1];

  always_comb begin
    dx       = $signed({2'b00, out_pix.x}) - $signed({2'b00, cursor_x});
    dy       = $signed({2'b00, out_pix.y}) - $signed({2'b00, cursor_y});
    adx      = (dx < 0) ? -dx : dx;
    ady      = (dy < 0) ? -dy : dy;
    rad_s    = $signed({{(SW-6){1'b0}}, radius});
    on_cross = ((dx == '0) && (ady <= rad_s)) || ((dy == '0) && (adx <= rad_s));

    rgb_next = '0;
    if (!out_pix.active || state == ST_INIT) rgb_next = '0;
    else if (preview)                        rgb_next = expand_rgb(brush_color);
    else if (cursor_valid && on_cross)       rgb_next = 24'hFF0000;
    else                                     rgb_next = expand_rgb(rd_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {vga_r, vga_g, vga_b} <= '0;
    else          {vga_r, vga_g, vga_b} <= rgb_next;
  end

endmodule

// File: tb/tb_vga_paint_compositor.sv
// Self-checking bench for vga_paint_compositor: vector tables, directed corner
// sequences and randomized pixels/detections against a behavioural model.
module tb_vga_paint_compositor;
  localparam int RD_LAT = 2;
  localparam int LAT    = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0, mem_init_done = 1'b0;
  logic [10:0] vga_x = '0, vga_y = '0, det_x = '0, det_y = '0;
  logic        vga_active = 1'b0, vga_vs = 1'b0, det_valid = 1'b0, preview = 1'b0;
  logic [5:0]  radius = '0;
  logic [8:0]  brush_color = '0;
  logic [8:0]  rd_data;
  logic        mem_init_req, rd_en, cursor_valid;
  logic [19:0] rd_addr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [10:0] cursor_x, cursor_y;
  logic [23:0] rgb;

  int checks = 0;
  int failures = 0;

  vga_paint_compositor #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mem_init_req(mem_init_req),
    .mem_init_done(mem_init_done), .vga_x(vga_x), .vga_y(vga_y), .vga_active(vga_active),
    .vga_vs(vga_vs), .det_valid(det_valid), .det_x(det_x), .det_y(det_y), .radius(radius),
    .preview(preview), .brush_color(brush_color), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_valid(cursor_valid)
  );

  always #10 clk = ~clk;
  assign rgb = {vga_r, vga_g, vga_b};

  // RAM image: fixed content per address, one special red word for the latency test.
  function automatic logic [8:0] ram_word(input logic [19:0] a);
    if (a == 20'd1290) return 9'o700;
    return 9'(a * 13 + (a >> 7));
  endfunction

  logic [8:0] ram_q [RD_LAT];
  always @(posedge clk) begin
    ram_q[0] <= ram_word(rd_addr);
    for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign rd_data = ram_q[RD_LAT-1];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cx = 0, m_cy = 0, m_tx = 0, m_ty = 0, m_lost = 0;
  bit m_cv = 0, m_seen = 0, m_run = 0;

  function automatic int floor_q(input int a);
    return (a >= 0) ? a / 4 : -((-a + 3) / 4);
  endfunction

  function automatic logic [7:0] exp8(input logic [2:0] v);
    return {v, v, v[2:1]};
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [8:0] c);
    return {exp8(c[8:6]), exp8(c[5:3]), exp8(c[2:0])};
  endfunction

  function automatic logic [19:0] addr_of(input int x, input int y);
    return 20'((y - 36) * 640 + (x - 145));
  endfunction

  function automatic logic [23:0] ram_rgb(input int x, input int y);
    return exp_rgb(ram_word(addr_of(x, y)));
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic logic [23:0] exp_pix(input int x, input int y, input bit a);
    int ddx, ddy;
    if (!a || !m_run) return 24'h0;
    if (preview) return exp_rgb(brush_color);
    ddx = x - m_cx;
    ddy = y - m_cy;
    if (m_cv && ((ddx == 0 && iabs(ddy) <= int'(radius)) ||
                 (ddy == 0 && iabs(ddx) <= int'(radius)))) return 24'hFF0000;
    return ram_rgb(x, y);
  endfunction

  task automatic model_detect(input int x, input int y);
    m_tx = (x > 639) ? 639 : x;
    m_ty = (y > 479) ? 479 : y;
    m_seen = 1;
  endtask

  task automatic model_vs();
    if (m_seen) begin
      if (!m_cv) begin
        m_cx = m_tx + 145;
        m_cy = m_ty + 36;
        m_cv = 1;
      end else begin
        m_cx = m_cx + floor_q(m_tx + 145 - m_cx);
        m_cy = m_cy + floor_q(m_ty + 36 - m_cy);
      end
      m_lost = 0;
    end else begin
      if (m_lost < 8) m_lost++;
      if (m_lost == 8) m_cv = 0;
    end
    m_seen = 0;
  endtask

  task automatic model_reset();
    m_cx = 0; m_cy = 0; m_tx = 0; m_ty = 0; m_lost = 0;
    m_cv = 0; m_seen = 0; m_run = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_pix(input int x, input int y, input bit a);
    vga_x = 11'(x);
    vga_y = 11'(y);
    vga_active = a;
  endtask

  task automatic detect(input int x, input int y);
    @(negedge clk);
    det_x = 11'(x); det_y = 11'(y); det_valid = 1'b1;
    @(negedge clk);
    det_valid = 1'b0;
    model_detect(x, y);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vga_vs = 1'b1;
    @(negedge clk);
    vga_vs = 1'b0;
    model_vs();
  endtask

  // Detection in the same clock as the vs edge: counts towards the next frame.
  task automatic vs_with_det(input int x, input int y);
    @(negedge clk);
    vga_vs = 1'b1; det_x = 11'(x); det_y = 11'(y); det_valid = 1'b1;
    @(negedge clk);
    vga_vs = 1'b0; det_valid = 1'b0;
    model_vs();
    model_detect(x, y);
  endtask

  task automatic probe(input string name, input int x, input int y, input bit red);
    @(negedge clk);
    drive_pix(x, y, 1'b1);
    repeat (LAT) @(posedge clk);
    #1 check(name, rgb, red ? 24'hFF0000 : ram_rgb(x, y));
  endtask

  task automatic check_cursor(input string name);
    check({name, "_valid"}, cursor_valid, m_cv);
    if (m_cv) check({name, "_xy"}, {cursor_x, cursor_y}, {11'(m_cx), 11'(m_cy)});
  endtask

  task automatic stream(input int n, input string tag);
    int hx[64], hy[64];
    bit ha[64];
    int x, y;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(100, 850));
        y = int'($urandom_range(20, 560));
      end else begin
        x = ($urandom_range(0, 1) == 0) ? m_cx : m_cx + int'($urandom_range(0, 50)) - 25;
        y = ($urandom_range(0, 1) == 0) ? m_cy : m_cy + int'($urandom_range(0, 50)) - 25;
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      hx[j] = x; hy[j] = y; ha[j] = ($urandom_range(0, 9) != 0);
      drive_pix(x, y, ha[j]);
      @(posedge clk);
      #1;
      if (j >= LAT - 1)
        check(tag, rgb, exp_pix(hx[j-LAT+1], hy[j-LAT+1], ha[j-LAT+1]));
    end
  endtask

  typedef struct {
    int         x;
    int         y;
    bit         a;
    logic [19:0] addr;
    bit         en;
  } addr_vec_t;

  typedef struct {
    logic [8:0]  brush;
    logic [23:0] rgb;
  } exp_vec_t;

  addr_vec_t av[6];
  exp_vec_t  ev[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    av[0] = '{155, 38, 1'b1, 20'd1290,    1'b1};
    av[1] = '{145, 36, 1'b1, 20'd0,       1'b1};
    av[2] = '{784, 515, 1'b1, 20'd307199, 1'b1};
    av[3] = '{200, 40, 1'b0, 20'd307199,  1'b0};
    av[4] = '{146, 36, 1'b1, 20'd1,       1'b1};
    av[5] = '{0,   0,  1'b1, 20'd1025391, 1'b1};
    ev[0] = '{9'o777, 24'hFFFFFF};
    ev[1] = '{9'o400, 24'h920000};
    ev[2] = '{9'o000, 24'h000000};
    ev[3] = '{9'o123, 24'h24496D};
    ev[4] = '{9'o070, 24'h00FF00};

    // T1: reset state and INIT hold
    #3 reset_n = 1'b0;
    #20;
    check("rst_req", mem_init_req, 1'b1);
    check("rst_outs", {rd_en, rd_addr, rgb, cursor_valid}, '0);
    check("rst_cursor", {cursor_x, cursor_y}, '0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive_pix(int'($urandom_range(145, 784)), int'($urandom_range(36, 515)),
                $urandom_range(0, 1) == 1);
      @(posedge clk);
      #1 check("t1_init_hold", {mem_init_req, rd_en, rgb}, {1'b1, 1'b0, 24'h0});
    end
    @(negedge clk);
    mem_init_done = 1'b1;
    vga_active = 1'b1;
    @(posedge clk);
    #1 check("t1_run_req", mem_init_req, 1'b0);
    check("t1_rden_lag", rd_en, 1'b0);
    m_run = 1;
    @(posedge clk);
    #1 check("t1_rden_on", rd_en, 1'b1);
    @(negedge clk) vga_active = 1'b0;
    @(posedge clk);
    #1 check("t1_rden_off", rd_en, 1'b0);

    // Address stage vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_pix(av[i].x, av[i].y, av[i].a);
      @(posedge clk);
      #1 check($sformatf("addr_vec%0d", i), {rd_en, rd_addr}, {av[i].en, av[i].addr});
    end

    // Brush expansion vectors via preview
    @(negedge clk);
    drive_pix(200, 100, 1'b1);
    preview = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) brush_color = ev[i].brush;
      repeat (LAT) @(posedge clk);
      #1 check($sformatf("expand_vec%0d", i), rgb, ev[i].rgb);
    end
    @(negedge clk) preview = 1'b0;

    // T2: exact latency of a single red RAM word
    vga_active = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk) drive_pix(155, 38, 1'b1);
    @(posedge clk);
    #1 check("t2_addr", rd_addr, 20'd1290);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(posedge clk);
      #1 check($sformatf("t2_lat_clk%0d", k), rgb, (k == LAT) ? 24'hFF0000 : 24'h0);
      if (k == 1) begin
        @(negedge clk) vga_active = 1'b0;
      end
    end

    // T3: first load then filtered steps
    detect(155, 164);
    vs_pulse();
    check("t3_load", {cursor_valid, cursor_x, cursor_y}, {1'b1, 11'd300, 11'd200});
    detect(255, 164); vs_pulse();
    check("t3_step1", {cursor_x, cursor_y}, {11'd325, 11'd200});
    detect(255, 164); vs_pulse();
    check("t3_step2", {cursor_x, cursor_y}, {11'd343, 11'd200});
    detect(255, 164); vs_pulse();
    check("t3_step3", {cursor_x, cursor_y}, {11'd357, 11'd200});

    // T4: lost after 8 silent frames, then direct reload
    repeat (7) vs_pulse();
    check("t4_valid_7", cursor_valid, 1'b1);
    vs_pulse();
    check("t4_drop_8", cursor_valid, 1'b0);
    detect(0, 1);
    vs_pulse();
    check("t4_reload", {cursor_valid, cursor_x, cursor_y}, {1'b1, 11'd145, 11'd37});

    // T5: crosshair limits and no wrap near the top of the coordinate range
    radius = 6'd20;
    probe("t5_v_end",   145, 57, 1'b1);
    probe("t5_v_past",  145, 58, 1'b0);
    probe("t5_v_top",   145, 17, 1'b1);
    probe("t5_v_above", 145, 16, 1'b0);
    probe("t5_h_end",   165, 37, 1'b1);
    probe("t5_h_past",  166, 37, 1'b0);
    probe("t5_h_left",  125, 37, 1'b1);
    probe("t5_h_out",   124, 37, 1'b0);
    probe("t5_off",     150, 40, 1'b0);
    radius = 6'd63;
    probe("t5_wrap2040", 145, 2040, 1'b0);
    probe("t5_wrap2047", 145, 2047, 1'b0);
    probe("t5_y0",       145, 0,    1'b1);
    probe("t5_r63",      145, 100,  1'b1);
    probe("t5_r64",      145, 101,  1'b0);

    // T6: clear during RUN with preview
    @(negedge clk);
    preview = 1'b1;
    brush_color = 9'o777;
    drive_pix(300, 300, 1'b1);
    repeat (LAT) @(posedge clk);
    #1 check("t6_preview", rgb, 24'hFFFFFF);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 check("t6_init_req", mem_init_req, 1'b1);
    @(negedge clk) clear = 1'b0;
    @(posedge clk);
    #1 check("t6_rgb0", rgb, 24'h0);
    check("t6_rerun", mem_init_req, 1'b0);
    @(negedge clk) clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("t6_clear_prio", mem_init_req, 1'b1);
    end
    @(negedge clk) clear = 1'b0;
    @(posedge clk);
    #1 check("t6_release", mem_init_req, 1'b0);
    check("t6_cursor_kept", cursor_valid, 1'b1);
    @(negedge clk) preview = 1'b0;

    // Mid-frame reset, then first detection loads directly
    #5 reset_n = 1'b0;
    #1 check("mrst_outs", {mem_init_req, rd_en, cursor_valid, rgb}, {1'b1, 1'b0, 1'b0, 24'h0});
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 m_run = 1;
    detect(400, 300);
    vs_pulse();
    check("mrst_reload", {cursor_valid, cursor_x, cursor_y}, {1'b1, 11'd545, 11'd336});

    // Randomized frames against the model
    for (int f = 0; f < 6; f++) begin
      int nd;
      nd = (f == 3) ? 0 : int'($urandom_range(0, 2));
      for (int d = 0; d < nd; d++)
        detect(int'($urandom_range(0, 900)), int'($urandom_range(0, 700)));
      if (f == 2) vs_with_det(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      else        vs_pulse();
      check_cursor($sformatf("rnd_cursor_f%0d", f));
      @(negedge clk);
      preview = ($urandom_range(0, 4) == 0);
      brush_color = 9'($urandom_range(0, 511));
      radius = 6'($urandom_range(0, 63));
      stream(30, $sformatf("rnd_pix_f%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
